// File: rtl/common_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : common_types_pkg
// Description : Shared types for the writeback stage and its machine CSR file:
//               CSR address map, write-source select, load size and CSR
//               read-modify-write operation, plus the RMW helper function.
// Revision    : 1.0 - initial release
// ============================================================================
package common_types_pkg;

    typedef enum logic [11:0] {
        CSR_MSTATUS   = 12'h300,
        CSR_MTVEC     = 12'h305,
        CSR_MSCRATCH  = 12'h340,
        CSR_MEPC      = 12'h341,
        CSR_MCAUSE    = 12'h342,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_MCYCLEH   = 12'hB80,
        CSR_MINSTRETH = 12'hB82,
        CSR_CYCLE     = 12'hC00,
        CSR_INSTRET   = 12'hC02,
        CSR_CYCLEH    = 12'hC80,
        CSR_INSTRETH  = 12'hC82
    } csr_addr_t;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_MEM = 2'd1,
        WB_SRC_PC4 = 2'd2,
        WB_SRC_CSR = 2'd3
    } wb_src_t;

    // Encoding 3 is not a legal size and is handled as a word load.
    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    // Encoding 3 performs no write.
    typedef enum logic [1:0] {
        CSR_OP_MOVE  = 2'd0,
        CSR_OP_SET   = 2'd1,
        CSR_OP_CLEAR = 2'd2
    } csr_op_t;

    // Returns the value a CSR instruction would write; op 3 returns old so
    // that a stray write cannot corrupt state even if it were enabled.
    function automatic logic [31:0] csr_rmw(
        input logic [1:0]  op,
        input logic [31:0] old_val,
        input logic [31:0] src
    );
        case (op)
            CSR_OP_MOVE:  return src;
            CSR_OP_SET:   return old_val | src;
            CSR_OP_CLEAR: return old_val & ~src;
            default:      return old_val;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module      : csr_file
// Description : Machine CSR file: address decode, old-value read mux,
//               read-modify-write, write masks and 64-bit cycle/instret
//               counters. Counters (and their read-only user aliases) exist
//               only when CSR_COUNTERS_EN is defined; otherwise their
//               addresses read 0 and ignore writes.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_we           - CSR instruction commits this cycle
//               i_retire       - an instruction retires this cycle
//               i_cnt_en       - cycle counter advances this cycle
//               i_addr, i_op   - CSR address and RMW operation
//               i_src          - RMW source operand
//               o_rdata        - pre-write contents of i_addr
// Revision    : 1.0 - initial release
// ============================================================================
module csr_file
    import common_types_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] MSTATUS_WMASK = 32'h0000_0088
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic            i_retire,
    input  logic            i_cnt_en,
    input  logic [11:0]     i_addr,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_src,
    output logic [XLEN-1:0] o_rdata
);

    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;

    logic [XLEN-1:0] w_cnt_rdata;
    logic [XLEN-1:0] w_new;
    logic            w_wr;

    always_comb begin
        o_rdata = '0;
        case (i_addr)
            CSR_MSTATUS:  o_rdata = r_mstatus;
            CSR_MTVEC:    o_rdata = r_mtvec;
            CSR_MSCRATCH: o_rdata = r_mscratch;
            CSR_MEPC:     o_rdata = r_mepc;
            CSR_MCAUSE:   o_rdata = r_mcause;
            default:      o_rdata = w_cnt_rdata;
        endcase
    end

    assign w_new = csr_rmw(i_op, o_rdata, i_src);
    assign w_wr  = i_we & (i_op != 2'd3);

    // Read-only and unimplemented addresses simply never match a write
    // decode below, so their writes drop silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus  <= '0;
            r_mtvec    <= '0;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
        end else if (w_wr) begin
            case (i_addr)
                CSR_MSTATUS:  r_mstatus  <= w_new & MSTATUS_WMASK;
                CSR_MTVEC:    r_mtvec    <= {w_new[XLEN-1:2], 2'b00};
                CSR_MSCRATCH: r_mscratch <= w_new;
                CSR_MEPC:     r_mepc     <= {w_new[XLEN-1:1], 1'b0};
                CSR_MCAUSE:   r_mcause   <= w_new;
                default:      ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    localparam logic [2*XLEN-1:0] c_cnt_one = {{(2*XLEN-1){1'b0}}, 1'b1};

    logic [2*XLEN-1:0] r_mcycle;
    logic [2*XLEN-1:0] r_minstret;

    logic w_wr_mcycle_lo;
    logic w_wr_mcycle_hi;
    logic w_wr_minstret_lo;
    logic w_wr_minstret_hi;

    assign w_wr_mcycle_lo   = w_wr & (i_addr == CSR_MCYCLE);
    assign w_wr_mcycle_hi   = w_wr & (i_addr == CSR_MCYCLEH);
    assign w_wr_minstret_lo = w_wr & (i_addr == CSR_MINSTRET);
    assign w_wr_minstret_hi = w_wr & (i_addr == CSR_MINSTRETH);

    // A software write to either half suppresses that counter's increment
    // for the cycle; the untouched half holds its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcycle <= '0;
        end else if (w_wr_mcycle_lo) begin
            r_mcycle[XLEN-1:0] <= w_new;
        end else if (w_wr_mcycle_hi) begin
            r_mcycle[2*XLEN-1:XLEN] <= w_new;
        end else if (i_cnt_en) begin
            r_mcycle <= r_mcycle + c_cnt_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_minstret <= '0;
        end else if (w_wr_minstret_lo) begin
            r_minstret[XLEN-1:0] <= w_new;
        end else if (w_wr_minstret_hi) begin
            r_minstret[2*XLEN-1:XLEN] <= w_new;
        end else if (i_retire) begin
            r_minstret <= r_minstret + c_cnt_one;
        end
    end

    always_comb begin
        w_cnt_rdata = '0;
        case (i_addr)
            CSR_MCYCLE,    CSR_CYCLE:    w_cnt_rdata = r_mcycle[XLEN-1:0];
            CSR_MCYCLEH,   CSR_CYCLEH:   w_cnt_rdata = r_mcycle[2*XLEN-1:XLEN];
            CSR_MINSTRET,  CSR_INSTRET:  w_cnt_rdata = r_minstret[XLEN-1:0];
            CSR_MINSTRETH, CSR_INSTRETH: w_cnt_rdata = r_minstret[2*XLEN-1:XLEN];
            default:                     w_cnt_rdata = '0;
        endcase
    end
`else
    logic w_unused_cnt;

    assign w_cnt_rdata  = '0;
    assign w_unused_cnt = &{1'b0, i_retire, i_cnt_en};
`endif

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Final pipeline stage. Extracts and extends load data,
//               selects the register-file write source, hosts the machine
//               CSR file and owns the sticky halt flag. Optional counters
//               are enabled with the macro CSR_COUNTERS_EN.
// Ports       : CLK, nRST            - clock, async active-low reset
//               wb_valid, pc, halt   - latched instruction state
//               rd, rs1, rdat1       - register indices / rs1 value
//               reg_wr_src/_mem/_mem_signed - write source and load format
//               csr_write/_waddr/_wr_op/_wr_imm - CSR instruction fields
//               alu_out, dload       - ALU result / load address, load word
//               rf_wen, rf_wsel, rf_wdat - register-file write port
//               halt_o, retire       - sticky halt, retire strobe
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
    import common_types_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] MSTATUS_WMASK = 32'h0000_0088
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            wb_valid,
    input  logic [XLEN-1:0] pc,
    input  logic            halt,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [XLEN-1:0] rdat1,
    input  logic [1:0]      reg_wr_src,
    input  logic [1:0]      reg_wr_mem,
    input  logic            reg_wr_mem_signed,
    input  logic            csr_write,
    input  logic [11:0]     csr_waddr,
    input  logic [1:0]      csr_wr_op,
    input  logic            csr_wr_imm,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] dload,
    output logic            rf_wen,
    output logic [4:0]      rf_wsel,
    output logic [XLEN-1:0] rf_wdat,
    output logic            halt_o,
    output logic            retire
);

    localparam logic [XLEN-1:0] c_pc_step = {{(XLEN-3){1'b0}}, 3'b100};

    logic            r_halted;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_csr_src;
    logic [XLEN-1:0] w_csr_rdata;
    logic            w_csr_we;

    assign halt_o   = r_halted;
    assign retire   = wb_valid & ~r_halted;
    assign rf_wen   = retire & ~halt & (rd != 5'd0);
    assign rf_wsel  = rd;

    // The halting instruction itself commits no CSR side effect.
    assign w_csr_we  = retire & csr_write & ~halt;
    assign w_csr_src = csr_wr_imm ? {{(XLEN-5){1'b0}}, rs1} : rdat1;

    always_comb begin
        case (alu_out[1:0])
            2'd0:    w_byte = dload[7:0];
            2'd1:    w_byte = dload[15:8];
            2'd2:    w_byte = dload[23:16];
            default: w_byte = dload[31:24];
        endcase
    end

    // alu_out[0] is ignored for halves; misaligned halves trap upstream.
    assign w_half = alu_out[1] ? dload[31:16] : dload[15:0];

    always_comb begin
        w_load = dload;
        case (reg_wr_mem)
            MEM_BYTE: w_load = {{(XLEN-8){reg_wr_mem_signed & w_byte[7]}}, w_byte};
            MEM_HALF: w_load = {{(XLEN-16){reg_wr_mem_signed & w_half[15]}}, w_half};
            default:  w_load = dload;
        endcase
    end

    always_comb begin
        rf_wdat = alu_out;
        case (reg_wr_src)
            WB_SRC_ALU: rf_wdat = alu_out;
            WB_SRC_MEM: rf_wdat = w_load;
            WB_SRC_PC4: rf_wdat = pc + c_pc_step;
            WB_SRC_CSR: rf_wdat = w_csr_rdata;
            default:    rf_wdat = alu_out;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_halted <= 1'b0;
        end else if (retire & halt) begin
            r_halted <= 1'b1;
        end
    end

    csr_file #(
        .XLEN          (XLEN),
        .MSTATUS_WMASK (MSTATUS_WMASK)
    ) u_csr_file (
        .clk      (CLK),
        .rst_n    (nRST),
        .i_we     (w_csr_we),
        .i_retire (retire),
        .i_cnt_en (~r_halted),
        .i_addr   (csr_waddr),
        .i_op     (csr_wr_op),
        .i_src    (w_csr_src),
        .o_rdata  (w_csr_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Self-checking bench for writeback_stage. A behavioural model
//               of the architectural state (CSRs, 64-bit counters, halt)
//               predicts every output; scenario tasks drive stimulus and
//               compare inline. Counter expectations follow CSR_COUNTERS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

`ifdef CSR_COUNTERS_EN
    localparam bit COUNTERS = 1'b1;
`else
    localparam bit COUNTERS = 1'b0;
`endif

    typedef struct {
        bit          valid;
        bit          halt;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [31:0] rdat1;
        logic [1:0]  src;
        logic [1:0]  msz;
        bit          sgn;
        bit          cw;
        logic [11:0] addr;
        logic [1:0]  op;
        bit          imm;
        logic [31:0] alu;
        logic [31:0] dload;
    } stim_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        wb_valid, halt, reg_wr_mem_signed, csr_write, csr_wr_imm;
    logic [31:0] pc, rdat1, alu_out, dload;
    logic [4:0]  rd, rs1;
    logic [1:0]  reg_wr_src, reg_wr_mem, csr_wr_op;
    logic [11:0] csr_waddr;
    logic        rf_wen, halt_o, retire;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;

    int errors = 0;
    int checks = 0;

    // Architectural model state
    logic [63:0] m_cyc, m_inst;
    logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
    bit          m_halted;
    stim_t       cur;

    logic [11:0] addr_list [16] = '{12'h300, 12'h305, 12'h340, 12'h341,
                                    12'h342, 12'hB00, 12'hB80, 12'hB02,
                                    12'hB82, 12'hC00, 12'hC80, 12'hC02,
                                    12'hC82, 12'h123, 12'h344, 12'hC01};

    always #5 CLK = ~CLK;

    writeback_stage dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .wb_valid          (wb_valid),
        .pc                (pc),
        .halt              (halt),
        .rd                (rd),
        .rs1               (rs1),
        .rdat1             (rdat1),
        .reg_wr_src        (reg_wr_src),
        .reg_wr_mem        (reg_wr_mem),
        .reg_wr_mem_signed (reg_wr_mem_signed),
        .csr_write         (csr_write),
        .csr_waddr         (csr_waddr),
        .csr_wr_op         (csr_wr_op),
        .csr_wr_imm        (csr_wr_imm),
        .alu_out           (alu_out),
        .dload             (dload),
        .rf_wen            (rf_wen),
        .rf_wsel           (rf_wsel),
        .rf_wdat           (rf_wdat),
        .halt_o            (halt_o),
        .retire            (retire)
    );

    // ---------------- reference model ----------------
    function automatic stim_t idle();
        stim_t t;
        t.valid = 0; t.halt = 0; t.pc = '0; t.rd = '0; t.rs1 = '0;
        t.rdat1 = '0; t.src = '0; t.msz = 2'd2; t.sgn = 0; t.cw = 0;
        t.addr = '0; t.op = '0; t.imm = 0; t.alu = '0; t.dload = '0;
        return t;
    endfunction

    function automatic logic [31:0] m_csr(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_inst[31:0];
            12'hB82, 12'hC82: return m_inst[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input stim_t t);
        logic [31:0] v;
        int          sh;
        if (t.msz == 2'd0) begin
            sh = 8 * int'(t.alu[1:0]);
            v  = (t.dload >> sh) & 32'hFF;
            if (t.sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (t.msz == 2'd1) begin
            sh = t.alu[1] ? 16 : 0;
            v  = (t.dload >> sh) & 32'hFFFF;
            if (t.sgn && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = t.dload;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_wdat(input stim_t t);
        case (t.src)
            2'd0:    return t.alu;
            2'd1:    return exp_load(t);
            2'd2:    return t.pc + 32'd4;
            default: return m_csr(t.addr);
        endcase
    endfunction

    function automatic bit exp_retire(input stim_t t);
        return t.valid && !m_halted;
    endfunction

    function automatic bit exp_wen(input stim_t t);
        return exp_retire(t) && !t.halt && (t.rd != 5'd0);
    endfunction

    task automatic model_reset();
        m_cyc = '0; m_inst = '0; m_halted = 0;
        m_mstatus = '0; m_mtvec = '0; m_mscratch = '0; m_mepc = '0; m_mcause = '0;
    endtask

    task automatic model_tick(input stim_t t);
        bit          ret, wr, cyc_w, inst_w;
        logic [31:0] src, oldv, nv;
        ret    = exp_retire(t);
        wr     = ret && t.cw && !t.halt && (t.op != 2'd3);
        src    = t.imm ? {27'b0, t.rs1} : t.rdat1;
        oldv   = m_csr(t.addr);
        nv     = (t.op == 2'd0) ? src : (t.op == 2'd1) ? (oldv | src) : (oldv & ~src);
        cyc_w  = 0;
        inst_w = 0;
        if (wr) begin
            case (t.addr)
                12'h300: m_mstatus  = nv & 32'h0000_0088;
                12'h305: m_mtvec    = nv & ~32'h3;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc     = nv & ~32'h1;
                12'h342: m_mcause   = nv;
                12'hB00: if (COUNTERS) begin m_cyc[31:0]   = nv; cyc_w = 1;  end
                12'hB80: if (COUNTERS) begin m_cyc[63:32]  = nv; cyc_w = 1;  end
                12'hB02: if (COUNTERS) begin m_inst[31:0]  = nv; inst_w = 1; end
                12'hB82: if (COUNTERS) begin m_inst[63:32] = nv; inst_w = 1; end
                default: ;
            endcase
        end
        if (COUNTERS && !m_halted && !cyc_w) m_cyc = m_cyc + 64'd1;
        if (COUNTERS && ret && !inst_w)      m_inst = m_inst + 64'd1;
        if (ret && t.halt)                   m_halted = 1;
    endtask

    // ---------------- stimulus plumbing ----------------
    task automatic drive(input stim_t t);
        cur = t;
        wb_valid = t.valid; halt = t.halt; pc = t.pc; rd = t.rd; rs1 = t.rs1;
        rdat1 = t.rdat1; reg_wr_src = t.src; reg_wr_mem = t.msz;
        reg_wr_mem_signed = t.sgn; csr_write = t.cw; csr_waddr = t.addr;
        csr_wr_op = t.op; csr_wr_imm = t.imm; alu_out = t.alu; dload = t.dload;
        #1;
    endtask

    task automatic step();
        @(posedge CLK);
        model_tick(cur);
        @(negedge CLK);
    endtask

    function automatic stim_t csr_rd(input logic [11:0] a);
        stim_t t = idle();
        t.src = 2'd3; t.addr = a;
        return t;
    endfunction

    function automatic stim_t csr_wr(input logic [11:0] a, input logic [1:0] op,
                                     input logic [31:0] v);
        stim_t t = idle();
        t.valid = 1; t.cw = 1; t.addr = a; t.op = op; t.rdat1 = v; t.src = 2'd3;
        return t;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        drive(idle());
        nRST = 1'b0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        drive(csr_rd(12'hB00));
        checks++;
        if (rf_wdat !== 32'h0) begin errors++; $display("FAIL reset_mcycle got=%h exp=%h", rf_wdat, 32'h0); end
        checks++;
        if (halt_o !== 1'b0 || retire !== 1'b0 || rf_wen !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b%b%b exp=000", halt_o, retire, rf_wen);
        end
        step();
        for (int i = 0; i < 16; i++) begin
            drive(csr_rd(addr_list[i]));
            checks++;
            if (rf_wdat !== m_csr(addr_list[i])) begin
                errors++; $display("FAIL reset_csr addr=%h got=%h exp=%h", addr_list[i], rf_wdat, m_csr(addr_list[i]));
            end
            step();
        end
    endtask

    task automatic test_load();
        stim_t t = idle();
        t.valid = 1; t.rd = 5'd3; t.src = 2'd1; t.msz = 2'd0; t.sgn = 1;
        t.dload = 32'h80FF_7F01; t.alu = 32'h0000_1003;
        drive(t);
        checks++;
        if (rf_wdat !== 32'hFFFF_FF80 || rf_wen !== 1'b1) begin
            errors++; $display("FAIL load_byte_signed got=%h/%b exp=ffffff80/1", rf_wdat, rf_wen);
        end
        step();
        t.msz = 2'd1; t.sgn = 0; t.alu = 32'h0000_2002;
        drive(t);
        checks++;
        if (rf_wdat !== 32'h0000_80FF) begin
            errors++; $display("FAIL load_half_unsigned got=%h exp=000080ff", rf_wdat);
        end
        step();
        for (int i = 0; i < 40; i++) begin
            t = idle();
            t.valid = 1; t.rd = 5'($urandom_range(0, 31)); t.src = 2'd1;
            t.msz = 2'($urandom_range(0, 3)); t.sgn = 1'($urandom_range(0, 1));
            t.dload = $urandom(); t.alu = $urandom();
            drive(t);
            checks++;
            if (rf_wdat !== exp_wdat(t) || rf_wsel !== t.rd || rf_wen !== exp_wen(t)) begin
                errors++; $display("FAIL load_rand sz=%0d got=%h exp=%h wen=%b", t.msz, rf_wdat, exp_wdat(t), rf_wen);
            end
            step();
        end
        t = idle(); t.valid = 1; t.rd = 5'd9; t.src = 2'd2; t.pc = 32'hFFFF_FFFC;
        drive(t);
        checks++;
        if (rf_wdat !== 32'h0) begin errors++; $display("FAIL pc4_wrap got=%h exp=00000000", rf_wdat); end
        step();
    endtask

    task automatic test_csr_seq();
        stim_t t;
        drive(csr_wr(12'h340, 2'd0, 32'hF0F0_0000));
        step();
        t = csr_wr(12'h340, 2'd1, 32'h0000_00FF); t.rd = 5'd5;
        drive(t);
        checks++;
        if (rf_wdat !== 32'hF0F0_0000 || rf_wen !== 1'b1) begin
            errors++; $display("FAIL csrrs_old got=%h/%b exp=f0f00000/1", rf_wdat, rf_wen);
        end
        step();
        drive(csr_rd(12'h340));
        checks++;
        if (rf_wdat !== 32'hF0F0_00FF) begin errors++; $display("FAIL csrrs_new got=%h exp=f0f000ff", rf_wdat); end
        step();
        t = csr_wr(12'h340, 2'd2, 32'h0); t.imm = 1; t.rs1 = 5'h1F;
        drive(t);
        step();
        drive(csr_rd(12'h340));
        checks++;
        if (rf_wdat !== 32'hF0F0_00E0) begin errors++; $display("FAIL csrrci got=%h exp=f0f000e0", rf_wdat); end
        step();
        drive(csr_wr(12'h340, 2'd3, 32'h0)); step();
        drive(csr_wr(12'h300, 2'd0, 32'hFFFF_FFFF)); step();
        drive(csr_wr(12'h305, 2'd0, 32'hFFFF_FFFF)); step();
        drive(csr_wr(12'h341, 2'd0, 32'hFFFF_FFFF)); step();
        drive(csr_wr(12'hC00, 2'd0, 32'h1234_5678)); step();
        drive(csr_wr(12'h123, 2'd0, 32'h1234_5678)); step();
        begin
            logic [11:0] ra [5] = '{12'h340, 12'h300, 12'h305, 12'h341, 12'h123};
            logic [31:0] rv [5] = '{32'hF0F0_00E0, 32'h88, 32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0};
            for (int i = 0; i < 5; i++) begin
                drive(csr_rd(ra[i]));
                checks++;
                if (rf_wdat !== rv[i]) begin
                    errors++; $display("FAIL csr_mask addr=%h got=%h exp=%h", ra[i], rf_wdat, rv[i]);
                end
                step();
            end
        end
        drive(csr_rd(12'hC00));
        checks++;
        if (rf_wdat !== m_csr(12'hC00)) begin errors++; $display("FAIL csr_ro_ignored got=%h exp=%h", rf_wdat, m_csr(12'hC00)); end
        step();
    endtask

    task automatic test_rd0();
        stim_t       t = idle();
        logic [31:0] inst0;
        t.valid = 1; t.rd = 5'd0; t.src = 2'd0; t.alu = 32'h0000_1234;
        inst0 = m_inst[31:0];
        drive(t);
        checks++;
        if (rf_wen !== 1'b0 || retire !== 1'b1 || rf_wdat !== 32'h1234) begin
            errors++; $display("FAIL rd0 got wen=%b ret=%b dat=%h exp 0/1/00001234", rf_wen, retire, rf_wdat);
        end
        step();
        drive(csr_rd(12'hB02));
        checks++;
        if (rf_wdat !== (COUNTERS ? inst0 + 32'd1 : 32'h0)) begin
            errors++; $display("FAIL rd0_minstret got=%h exp=%h", rf_wdat, COUNTERS ? inst0 + 32'd1 : 32'h0);
        end
        step();
    endtask

    task automatic test_counters();
        stim_t t;
        drive(csr_wr(12'hB00, 2'd0, 32'hFFFF_FFFF)); step();
        drive(csr_wr(12'hB80, 2'd0, 32'h0));         step();
        drive(csr_rd(12'hB00));
        checks++;
        if (rf_wdat !== (COUNTERS ? 32'hFFFF_FFFF : 32'h0)) begin
            errors++; $display("FAIL cnt_forced got=%h exp=%h", rf_wdat, COUNTERS ? 32'hFFFF_FFFF : 32'h0);
        end
        step();
        drive(csr_rd(12'hB00));
        checks++;
        if (rf_wdat !== 32'h0) begin errors++; $display("FAIL cnt_carry_lo got=%h exp=00000000", rf_wdat); end
        step();
        drive(csr_rd(12'hC80));
        checks++;
        if (rf_wdat !== (COUNTERS ? 32'h1 : 32'h0)) begin
            errors++; $display("FAIL cnt_carry_hi got=%h exp=%h", rf_wdat, COUNTERS ? 32'h1 : 32'h0);
        end
        step();
        drive(csr_wr(12'hB00, 2'd0, 32'h7)); step();
        drive(csr_rd(12'hB00));
        checks++;
        if (rf_wdat !== (COUNTERS ? 32'h7 : 32'h0)) begin
            errors++; $display("FAIL cnt_wr_priority got=%h exp=%h", rf_wdat, COUNTERS ? 32'h7 : 32'h0);
        end
        step();
        drive(csr_wr(12'hB02, 2'd0, 32'hFFFF_FFFF)); step();
        t = idle(); t.valid = 1; t.rd = 5'd1;
        drive(t); step();
        for (int i = 0; i < 4; i++) begin
            drive(csr_rd(i[0] ? 12'hC82 : 12'hB02));
            checks++;
            if (rf_wdat !== m_csr(i[0] ? 12'hC82 : 12'hB02)) begin
                errors++; $display("FAIL instret_carry i=%0d got=%h exp=%h", i, rf_wdat, m_csr(i[0] ? 12'hC82 : 12'hB02));
            end
            step();
        end
    endtask

    task automatic test_random();
        stim_t t;
        for (int i = 0; i < 200; i++) begin
            t = idle();
            t.valid = ($urandom_range(0, 3) != 0);
            t.pc = $urandom(); t.rd = 5'($urandom_range(0, 31)); t.rs1 = 5'($urandom_range(0, 31));
            t.rdat1 = $urandom(); t.src = 2'($urandom_range(0, 3)); t.msz = 2'($urandom_range(0, 3));
            t.sgn = 1'($urandom_range(0, 1)); t.cw = 1'($urandom_range(0, 1));
            t.addr = addr_list[$urandom_range(0, 15)]; t.op = 2'($urandom_range(0, 3));
            t.imm = 1'($urandom_range(0, 1)); t.alu = $urandom(); t.dload = $urandom();
            drive(t);
            checks++;
            if (rf_wdat !== exp_wdat(t) || rf_wen !== exp_wen(t) || retire !== exp_retire(t) || halt_o !== m_halted) begin
                errors++;
                $display("FAIL rand i=%0d got dat=%h wen=%b ret=%b hlt=%b exp dat=%h wen=%b ret=%b hlt=%b",
                         i, rf_wdat, rf_wen, retire, halt_o, exp_wdat(t), exp_wen(t), exp_retire(t), m_halted);
            end
            step();
        end
    endtask

    task automatic test_halt();
        stim_t       t;
        logic [31:0] inst0;
        inst0 = m_inst[31:0];
        t = csr_wr(12'h340, 2'd0, 32'hDEAD_BEEF); t.halt = 1; t.rd = 5'd7;
        drive(t);
        checks++;
        if (rf_wen !== 1'b0 || retire !== 1'b1 || halt_o !== 1'b0) begin
            errors++; $display("FAIL halt_instr got wen=%b ret=%b hlt=%b exp 0/1/0", rf_wen, retire, halt_o);
        end
        step();
        t = idle(); t.valid = 1; t.rd = 5'd4;
        drive(t);
        checks++;
        if (halt_o !== 1'b1 || retire !== 1'b0 || rf_wen !== 1'b0) begin
            errors++; $display("FAIL halted_state got hlt=%b ret=%b wen=%b exp 1/0/0", halt_o, retire, rf_wen);
        end
        step();
        drive(csr_rd(12'hB02));
        checks++;
        if (rf_wdat !== (COUNTERS ? inst0 + 32'd1 : 32'h0)) begin
            errors++; $display("FAIL halt_minstret got=%h exp=%h", rf_wdat, COUNTERS ? inst0 + 32'd1 : 32'h0);
        end
        step();
        drive(csr_rd(12'h340));
        checks++;
        if (rf_wdat !== m_mscratch) begin errors++; $display("FAIL halt_no_csr_wr got=%h exp=%h", rf_wdat, m_mscratch); end
        step();
        for (int i = 0; i < 3; i++) begin
            drive(csr_rd(12'hB00));
            checks++;
            if (rf_wdat !== m_csr(12'hB00)) begin errors++; $display("FAIL halt_mcycle_frozen got=%h exp=%h", rf_wdat, m_csr(12'hB00)); end
            step();
        end
        drive(idle());
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (halt_o !== 1'b0) begin errors++; $display("FAIL async_reset got=%b exp=0", halt_o); end
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
        drive(csr_rd(12'h340));
        checks++;
        if (rf_wdat !== 32'h0) begin errors++; $display("FAIL reset_mscratch got=%h exp=00000000", rf_wdat); end
        step();
    endtask

    initial begin
        cur = idle();
        drive(idle());
        model_reset();
        test_reset();
        test_load();
        test_csr_seq();
        test_rd0();
        test_counters();
        test_random();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
